// File: rtl/mul_pkg.sv
// Shared types and helpers for the multiply controller and its Booth/compression tree.
package mul_pkg;

  localparam int MUL_W     = 32;
  localparam int PP_NUM    = 17;
  localparam int PROD_W    = 64;
  localparam int EXT_W     = MUL_W + 1;
  localparam int CARRY_NUM = PP_NUM - 2;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_MADD  = 2'b10,
    OP_MSUB  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PP   = 2'b01,
    ST_CMP  = 2'b10,
    ST_ADD  = 2'b11
  } mul_state_e;

  typedef struct packed {
    logic [CARRY_NUM-1:0] cout;
    logic                 sum;
    logic                 carry;
  } col_out_t;

  // Radix-4 Booth partial product for group idx, fully negated and aligned to 64 bits.
  function automatic logic [PROD_W-1:0] booth_pp(input logic [EXT_W-1:0] mcand,
                                                 input logic [2:0]       grp,
                                                 input int               idx);
    logic [PROD_W-1:0] x;
    logic [PROD_W-1:0] m;
    logic [PROD_W-1:0] pp;
    x = {{(PROD_W-EXT_W){mcand[EXT_W-1]}}, mcand};
    case (grp)
      3'b001, 3'b010, 3'b101, 3'b110: m = x;
      3'b011, 3'b100:                 m = x << 1;
      default:                        m = '0;
    endcase
    pp = grp[2] ? (~m + PROD_W'(1)) : m;
    return pp << (2 * idx);
  endfunction

  // 17-input column slice: 15 full adders take 17 column bits plus 15 carries from the
  // previous column and leave one sum and one carry bit of this column's weight.
  function automatic col_out_t col_compress(input logic [PP_NUM-1:0]    bits,
                                            input logic [CARRY_NUM-1:0] cin);
    logic [PP_NUM+CARRY_NUM-1:0] b;
    logic a0, a1, a2;
    col_out_t r;
    r = '0;
    b = {cin, bits};
    for (int f = 0; f < CARRY_NUM; f++) begin
      a0 = b[2*f];
      a1 = b[2*f+1];
      a2 = b[2*f+2];
      b[2*f+2]  = a0 ^ a1 ^ a2;
      r.cout[f] = (a0 & a1) | (a0 & a2) | (a1 & a2);
    end
    r.sum   = b[2*CARRY_NUM];
    r.carry = b[2*CARRY_NUM+1];
    return r;
  endfunction

endpackage

// File: rtl/mul_tree.sv
// Booth encoder, 64 chained column compressors and the PP/CMP stage registers.
module mul_tree
  import mul_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              pp_en,
  input  logic              cmp_en,
  input  logic [EXT_W-1:0]  mcand,
  input  logic [EXT_W-1:0]  mplier,
  output logic [PROD_W-1:0] sum_row,
  output logic [PROD_W-1:0] carry_row
);

  logic [PROD_W-1:0] pp_d [PP_NUM];
  logic [PROD_W-1:0] pp_q [PP_NUM];
  logic [PROD_W-1:0] sum_d;
  logic [PROD_W-1:0] carry_d;
  logic [EXT_W+1:0]  mplier_x;

  // Extra sign bit on top, implicit zero below bit 0: 17 overlapping 3-bit groups.
  assign mplier_x = {mplier[EXT_W-1], mplier, 1'b0};

  always_comb begin
    for (int i = 0; i < PP_NUM; i++) begin
      pp_d[i] = booth_pp(mcand, mplier_x[2*i +: 3], i);
    end
  end

  always_comb begin
    logic [CARRY_NUM-1:0] cin;
    logic [PP_NUM-1:0]    bits;
    col_out_t             r;
    cin     = '0;
    bits    = '0;
    r       = '0;
    sum_d   = '0;
    carry_d = '0;
    for (int k = 0; k < PROD_W; k++) begin
      for (int j = 0; j < PP_NUM; j++) begin
        bits[j] = pp_q[j][k];
      end
      r          = col_compress(bits, cin);
      sum_d[k]   = r.sum;
      carry_d[k] = r.carry;
      cin        = r.cout;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < PP_NUM; i++) begin
        pp_q[i] <= '0;
      end
      sum_row   <= '0;
      carry_row <= '0;
    end else begin
      if (pp_en) begin
        for (int i = 0; i < PP_NUM; i++) begin
          pp_q[i] <= pp_d[i];
        end
      end
      if (cmp_en) begin
        sum_row   <= sum_d;
        carry_row <= carry_d;
      end
    end
  end

endmodule

// File: rtl/mul_ctrl.sv
// Multi-cycle multiply controller with architectural HI/LO; MUL_ACC_EN enables MADD/MSUB.
//   state | meaning
//   IDLE  | ready for a request; MTHI/MTLO honoured
//   PP    | Booth partial products being registered
//   CMP   | 17-to-2 column compression being registered
//   ADD   | final 64-bit add (and accumulate), HI/LO written at exit
module mul_ctrl
  import mul_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [MUL_W-1:0] src1,
  input  logic [MUL_W-1:0] src2,
  input  logic             flush,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [MUL_W-1:0] mt_wdata,
  output logic             busy,
  output logic             res_valid,
  output logic [MUL_W-1:0] hi,
  output logic [MUL_W-1:0] lo
);

  mul_state_e        state, state_nxt;
  logic              accept;
  logic              sign_ext;
  logic              pp_en, cmp_en, wr_prod;
  logic [EXT_W-1:0]  mcand_q, mplier_q;
  logic [PROD_W-1:0] sum_row, carry_row;
  logic [PROD_W-1:0] product;
  logic [PROD_W-1:0] hilo_nxt;

  assign req_ready = (state == ST_IDLE) & ~flush & resetn;
  assign accept    = req_valid & req_ready;
  assign busy      = (state != ST_IDLE);

`ifdef MUL_ACC_EN
  assign sign_ext = (req_op != OP_MULTU);
`else
  // Without the accumulator, MSUB degrades to MULTU and MADD to MULT.
  assign sign_ext = (req_op == OP_MULT) | (req_op == OP_MADD);
`endif

  always_comb begin
    state_nxt = state;
    pp_en     = 1'b0;
    cmp_en    = 1'b0;
    wr_prod   = 1'b0;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_PP;
      ST_PP: begin
        pp_en     = ~flush;
        state_nxt = flush ? ST_IDLE : ST_CMP;
      end
      ST_CMP: begin
        cmp_en    = ~flush;
        state_nxt = flush ? ST_IDLE : ST_ADD;
      end
      ST_ADD: begin
        wr_prod   = ~flush;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  mul_tree u_tree (
    .clk       (clk),
    .resetn    (resetn),
    .pp_en     (pp_en),
    .cmp_en    (cmp_en),
    .mcand     (mcand_q),
    .mplier    (mplier_q),
    .sum_row   (sum_row),
    .carry_row (carry_row)
  );

  assign product = sum_row + carry_row;

`ifdef MUL_ACC_EN
  mul_op_e op_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      op_q <= OP_MULT;
    end else if (accept) begin
      op_q <= mul_op_e'(req_op);
    end
  end

  always_comb begin
    hilo_nxt = product;
    case (op_q)
      OP_MADD: hilo_nxt = {hi, lo} + product;
      OP_MSUB: hilo_nxt = {hi, lo} - product;
      default: hilo_nxt = product;
    endcase
  end
`else
  assign hilo_nxt = product;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      hi        <= '0;
      lo        <= '0;
      res_valid <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
    end else begin
      state     <= state_nxt;
      res_valid <= wr_prod;
      if (accept) begin
        mcand_q  <= {sign_ext & src1[MUL_W-1], src1};
        mplier_q <= {sign_ext & src2[MUL_W-1], src2};
      end
      // MT writes land in the accept cycle too; the product overwrites them at ADD exit.
      if (state == ST_IDLE) begin
        if (mthi_we) hi <= mt_wdata;
        if (mtlo_we) lo <= mt_wdata;
      end
      if (wr_prod) begin
        {hi, lo} <= hilo_nxt;
      end
    end
  end

endmodule
